// File: rtl/gf2m_pkg.sv
// ----------------------------------------------------------------------------
// gf2m_pkg
// Shared definitions for the GF(2^163) digit-serial multiplier core.
//   GF_M         field degree (163)
//   SQ_W         width of an unreduced square (2*GF_M-1)
//   F_POLY       reduction polynomial x^163 + x^7 + x^6 + x^3 + 1, bit i = x^i
//   acb_state_e  FSM state encoding of gf2m_acb_core
//   digit_legal  returns 1 for supported digit widths (1,2,4,8,16,32)
//   gf2m_sqr     combinational squarer (bit spread + reduction), used only when
//                the core is built with ACB_FAST_SQR_EN
// ----------------------------------------------------------------------------
package gf2m_pkg;

  localparam int GF_M = 163;
  localparam int SQ_W = 2 * GF_M - 1;

  // x^163 + x^7 + x^6 + x^3 + 1
  localparam logic [GF_M:0] F_POLY = {1'b1, 155'd0, 8'hC9};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SQR      = 3'd1,
    ST_MUL      = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_LOW = 3'd4
  } acb_state_e;

  function automatic logic digit_legal(input int d);
    logic ok;
    case (d)
      1, 2, 4, 8, 16, 32: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Squaring in GF(2^m) is linear: spread bits to even positions, then reduce.
  // Reduction runs top-down so bits folded back above GF_M-1 are caught later.
  function automatic logic [GF_M-1:0] gf2m_sqr(input logic [GF_M-1:0] b);
    logic [SQ_W-1:0] s;
    s = '0;
    for (int i = 0; i < GF_M; i++) begin
      s[2*i] = b[i];
    end
    for (int k = SQ_W - 1; k >= GF_M; k--) begin
      s = s ^ ((SQ_W'(F_POLY) << (k - GF_M)) & {SQ_W{s[k]}});
    end
    return s[GF_M-1:0];
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// ----------------------------------------------------------------------------
// gf2m_digit_step
// One combinational MSB-first Horner step of a digit-serial GF(2^m) multiply:
//   acc_o = (acc_i * x^DIGIT + a_i * digit_i) mod F_POLY
// Inputs are assumed fully reduced (degree < M); the output is fully reduced.
// Ports:
//   acc_i    [M-1:0]      running accumulator
//   a_i      [M-1:0]      multiplicand
//   digit_i  [DIGIT-1:0]  current multiplier digit
//   acc_o    [M-1:0]      reduced next accumulator
// ----------------------------------------------------------------------------
module gf2m_digit_step
  import gf2m_pkg::*;
#(
  parameter int M     = GF_M,
  parameter int DIGIT = 8
) (
  input  logic [M-1:0]     acc_i,
  input  logic [M-1:0]     a_i,
  input  logic [DIGIT-1:0] digit_i,
  output logic [M-1:0]     acc_o
);

  localparam int W = M + DIGIT;
  localparam logic [W-1:0] POLY_EXT = W'(F_POLY);

  logic [W-1:0] prod_s;

  // Shift-accumulate the partial product, then fold the DIGIT overflow bits.
  always_comb begin
    prod_s = W'(acc_i) << DIGIT;
    for (int j = 0; j < DIGIT; j++) begin
      prod_s = prod_s ^ ((W'(a_i) << j) & {W{digit_i[j]}});
    end
    // Folded terms land at most DIGIT-1+7 above bit 0, always below M, so one
    // top-down pass leaves the result fully reduced.
    for (int k = W - 1; k >= M; k--) begin
      prod_s = prod_s ^ ((POLY_EXT << (k - M)) & {W{prod_s[k]}});
    end
  end

  assign acc_o = prod_s[M-1:0];

endmodule

// File: rtl/gf2m_acb_core.sv
// ----------------------------------------------------------------------------
// gf2m_acb_core
// Digit-serial GF(2^163) multiplier responder, f(x) = x^163+x^7+x^6+x^3+1.
//   configuration = 0 : C = A*B   mod f   (latency N+1 cycles)
//   configuration = 1 : C = A*B^2 mod f   (latency 2N+1, or N+2 with
//                                          ACB_FAST_SQR_EN defined)
// Optional build macro: ACB_FAST_SQR_EN -- square B in one cycle with a
// combinational squarer instead of N digit-serial cycles.
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         level request; operands are latched on the first cycle
//   A, B [M-1:0]   operands, polynomial basis (bit i = coeff of x^i)
//   configuration  0: A*B, 1: A*B^2
//   done           one-cycle pulse; C is valid in the same cycle
//   C    [M-1:0]   result register, held until the next completed operation
// Dropping enable during SQR/MUL aborts without done and leaves C unchanged.
// After done the core waits for enable low before accepting a new request.
// ----------------------------------------------------------------------------
module gf2m_acb_core
  import gf2m_pkg::*;
#(
  parameter int M     = GF_M,
  parameter int DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic         configuration,
  output logic         done,
  output logic [M-1:0] C
);

  localparam int N  = (M + DIGIT - 1) / DIGIT;  // digit steps per pass
  localparam int PW = N * DIGIT;                // zero-padded multiplier width
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (M != GF_M) begin : g_bad_m
    $error("gf2m_acb_core: M must be 163");
  end
  if (!digit_legal(DIGIT)) begin : g_bad_digit
    $error("gf2m_acb_core: DIGIT must be one of 1,2,4,8,16,32");
  end

  acb_state_e    state_q, state_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  opa_q, opa_d;
  logic [M-1:0]  opb_q, opb_d;
  logic [PW-1:0] sh_q, sh_d;   // multiplier digits, consumed MSB-first
  logic [M-1:0]  c_q, c_d;
  logic          done_q, done_d;

  logic [M-1:0]     a_sel_s;
  logic [DIGIT-1:0] digit_s;
  logic [M-1:0]     step_s;

  // SQR multiplies B by itself; MUL multiplies A by the (possibly squared) B.
  assign a_sel_s = (state_q == ST_SQR) ? opb_q : opa_q;
  assign digit_s = sh_q[PW-1 -: DIGIT];

  gf2m_digit_step #(
    .M     (M),
    .DIGIT (DIGIT)
  ) u_step (
    .acc_i   (acc_q),
    .a_i     (a_sel_s),
    .digit_i (digit_s),
    .acc_o   (step_s)
  );

`ifdef ACB_FAST_SQR_EN
  logic [M-1:0] sq_s;
  assign sq_s = gf2m_sqr(opb_q);
`endif

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sh_d    = sh_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          opa_d   = A;
          opb_d   = B;
          sh_d    = PW'(B);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = configuration ? ST_SQR : ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SQR: begin
        if (!enable) begin
          state_d = ST_IDLE;
`ifdef ACB_FAST_SQR_EN
        end else begin
          sh_d    = PW'(sq_s);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MUL;
        end
`else
        end else if (cnt_q == CW'(N - 1)) begin
          // B^2 becomes the multiplier for the following MUL pass.
          sh_d    = PW'(step_s);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MUL;
        end else begin
          acc_d   = step_s;
          sh_d    = sh_q << DIGIT;
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      ST_MUL: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(N - 1)) begin
          acc_d   = step_s;
          c_d     = step_s;
          state_d = ST_DONE;
        end else begin
          acc_d   = step_s;
          sh_d    = sh_q << DIGIT;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = enable ? ST_WAIT_LOW : ST_IDLE;
      end
      ST_WAIT_LOW: begin
        state_d = enable ? ST_WAIT_LOW : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sh_q    <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sh_q    <= sh_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign C    = c_q;

endmodule
